// File: rtl/inert_intf_ctrl.sv
// Inertial sensor command sequencer: waits out power-up, writes three config registers, then
// reads the yaw rate on each data-ready. Optional 4-sample averaging under INERT_YAW_AVG_EN.
module inert_intf_ctrl #(
    parameter int unsigned PWR_TMR_W = 16,
    parameter logic [15:0] CFG0      = 16'h0D02,
    parameter logic [15:0] CFG1      = 16'h1160,
    parameter logic [15:0] CFG2      = 16'h1440
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        init_done,
    output logic        vld,
    output logic [15:0] yaw_rt
);

    localparam logic [15:0] CmdYawL = 16'hA600;
    localparam logic [15:0] CmdYawH = 16'hA700;

    typedef enum logic [3:0] {
        StPwr, StCfg0, StWCfg0, StCfg1, StWCfg1, StCfg2, StWCfg2,
        StIdle, StWYl, StYh, StWYh
    } state_t;

    state_t               state;
    logic [PWR_TMR_W-1:0] tmr;
    logic                 int_ff1;
    logic                 int_ff2;
    logic [7:0]           yaw_l;
    logic [15:0]          sample;
    logic                 spi_done;
    logic                 unused_rd_hi;

    assign sample       = {rd_data[7:0], yaw_l};
    // done is stale while wrt is high: the SPI only clears it on that edge.
    assign spi_done     = done && !wrt;
    assign unused_rd_hi = ^rd_data[15:8];

`ifdef INERT_YAW_AVG_EN
    logic [15:0] hist [4];
    logic [17:0] sum;
    logic [17:0] sum_nxt;

    assign sum_nxt = sum + {{2{sample[15]}}, sample} - {{2{hist[3][15]}}, hist[3]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StPwr;
            tmr       <= '0;
            int_ff1   <= 1'b0;
            int_ff2   <= 1'b0;
            yaw_l     <= '0;
            wrt       <= 1'b0;
            cmd       <= '0;
            init_done <= 1'b0;
            vld       <= 1'b0;
            yaw_rt    <= '0;
`ifdef INERT_YAW_AVG_EN
            sum       <= '0;
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
`endif
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            wrt     <= 1'b0;
            vld     <= 1'b0;
            unique case (state)
                StPwr: begin
                    tmr <= tmr + PWR_TMR_W'(1);
                    if (tmr == '1) begin
                        state <= StCfg0;
                    end
                end
                StCfg0: begin
                    wrt   <= 1'b1;
                    cmd   <= CFG0;
                    state <= StWCfg0;
                end
                StWCfg0: begin
                    if (spi_done) begin
                        state <= StCfg1;
                    end
                end
                StCfg1: begin
                    wrt   <= 1'b1;
                    cmd   <= CFG1;
                    state <= StWCfg1;
                end
                StWCfg1: begin
                    if (spi_done) begin
                        state <= StCfg2;
                    end
                end
                StCfg2: begin
                    wrt   <= 1'b1;
                    cmd   <= CFG2;
                    state <= StWCfg2;
                end
                StWCfg2: begin
                    if (spi_done) begin
                        init_done <= 1'b1;
                        state     <= StIdle;
                    end
                end
                StIdle: begin
                    if (int_ff2) begin
                        wrt   <= 1'b1;
                        cmd   <= CmdYawL;
                        state <= StWYl;
                    end
                end
                StWYl: begin
                    if (spi_done) begin
                        yaw_l <= rd_data[7:0];
                        state <= StYh;
                    end
                end
                StYh: begin
                    wrt   <= 1'b1;
                    cmd   <= CmdYawH;
                    state <= StWYh;
                end
                StWYh: begin
                    if (spi_done) begin
`ifdef INERT_YAW_AVG_EN
                        sum     <= sum_nxt;
                        yaw_rt  <= sum_nxt[17:2];
                        hist[0] <= sample;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
`else
                        yaw_rt  <= sample;
`endif
                        vld     <= 1'b1;
                        state   <= StIdle;
                    end
                end
                default: state <= StPwr;
            endcase
        end
    end

endmodule
